// File: rtl/sign_mag_decode_if.sv
// Bundle for the sign/magnitude decoder: start/operand request plus status and result.
// Latency: n/a (wires only); timing is set by the decoder behind the slave modport.
// Backpressure: none; the master watches busy/done. ovf exists only with SIGN_MAG_OVF_EN.
interface sign_mag_decode_if;
  logic        start;
  logic [31:0] A;
  logic        busy;
  logic        done;
  logic        sign;
  logic [31:0] Mag;
`ifdef SIGN_MAG_OVF_EN
  logic        ovf;
`endif

`ifdef SIGN_MAG_OVF_EN
  modport master (output start, A, input busy, done, sign, Mag, ovf);
  modport slave  (input start, A, output busy, done, sign, Mag, ovf);
`else
  modport master (output start, A, input busy, done, sign, Mag);
  modport slave  (input start, A, output busy, done, sign, Mag);
`endif
endinterface

// File: rtl/sign_mag_decode.sv
// Sign/magnitude decoder: 32-bit two's-complement operand -> sign + magnitude (SIGN_MAG_OVF_EN adds ovf).
// Latency: 1 cycle for A[31]=0, 33 cycles for A[31]=1 (bit-serial negation, one bit per clk).
// Backpressure: none; start is only accepted in IDLE and silently ignored while busy.
module sign_mag_decode (
  input  logic             clk,
  input  logic             clr,
  sign_mag_decode_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]  state;
  logic [31:0] opnd;      // operand captured at accept; A itself is don't-care afterwards
  logic        seen_one;  // a '1' has already been passed below the current bit
  logic [4:0]  bit_cnt;   // index of the bit processed in this SHIFT cycle
  logic        sign_q;
  logic [31:0] mag_q;
`ifdef SIGN_MAG_OVF_EN
  logic        ovf_q;
`endif

  logic accept;
  logic cur_bit;
  logic new_bit;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign cur_bit = opnd[bit_cnt];
  // Serial negation: copy bits up to and including the first '1', invert the rest.
  assign new_bit = seen_one ? ~cur_bit : cur_bit;

  // Conversion FSM and datapath registers; clr wins over start and an in-flight SHIFT.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_IDLE;
      opnd     <= 32'd0;
      seen_one <= 1'b0;
      bit_cnt  <= 5'd0;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
`ifdef SIGN_MAG_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            opnd     <= bus.A;
            sign_q   <= bus.A[31];
            seen_one <= 1'b0;
            bit_cnt  <= 5'd0;
`ifdef SIGN_MAG_OVF_EN
            ovf_q    <= 1'b0;
`endif
            if (bus.A[31]) begin
              state <= ST_SHIFT;
            end else begin
              // Non-negative operands are already their own magnitude.
              mag_q <= bus.A;
              state <= ST_DONE;
            end
          end
        end

        ST_SHIFT: begin
          mag_q[bit_cnt] <= new_bit;
          seen_one       <= seen_one | cur_bit;
          bit_cnt        <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            state <= ST_DONE;
`ifdef SIGN_MAG_OVF_EN
            // The most negative value has no positive counterpart: saturate and flag it.
            // This later assignment overrides the bit-31 write above.
            if (opnd == 32'h8000_0000) begin
              mag_q <= 32'h7FFF_FFFF;
              ovf_q <= 1'b1;
            end
`endif
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = (state == ST_DONE);
  assign bus.sign = sign_q;
  assign bus.Mag  = mag_q;
`ifdef SIGN_MAG_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sign_mag_decode.sv
// Self-checking bench for sign_mag_decode: directed vector table, corner sequences, random vs model.
// Latency: checks 1-cycle positive path and 33-cycle negative path from the accept edge.
// Backpressure: exercises ignored starts in SHIFT/DONE and clr abandoning a conversion.
module tb_sign_mag_decode;

  logic clk;
  logic clr;
  int   checks;
  int   errors;

  sign_mag_decode_if bus ();

  sign_mag_decode dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic        exp_sign;
    logic [31:0] exp_mag;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // One clock, then settle past the edge before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Behavioural reference: magnitude of a 32-bit two's-complement number.
  function automatic logic [31:0] model_mag(input logic [31:0] a);
    logic [31:0] m;
    m = a[31] ? (32'd0 - a) : a;
`ifdef SIGN_MAG_OVF_EN
    if (a == 32'h8000_0000) m = 32'h7FFF_FFFF;
`endif
    return m;
  endfunction

  function automatic logic model_ovf(input logic [31:0] a);
`ifdef SIGN_MAG_OVF_EN
    return (a == 32'h8000_0000);
`else
    return 1'b0 & a[0];
`endif
  endfunction

  function automatic logic get_ovf();
`ifdef SIGN_MAG_OVF_EN
    return bus.ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Pulse start with operand a, then wait (bounded) for done, scrambling A meanwhile.
  task automatic run_conv(input logic [31:0] a, output int lat, output int busy_n);
    bus.start = 1'b1;
    bus.A     = a;
    tick();
    bus.start = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_n++;
      bus.A = $urandom;
      tick();
      lat++;
    end
    if (bus.busy) busy_n++;
  endtask

  initial begin
    int lat;
    int busy_n;
    int pulses;
    logic [31:0] a;
    logic [31:0] hold_mag;
    logic        hold_sign;

    checks = 0;
    errors = 0;

    vecs[0] = '{32'h0000_0005, 1'b0, 32'h0000_0005, 1};
    vecs[1] = '{32'hFFFF_FFFB, 1'b1, 32'h0000_0005, 33};
    vecs[2] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1};
    vecs[3] = '{32'hFFFF_FFFE, 1'b1, 32'h0000_0002, 33};
    vecs[4] = '{32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1};
    vecs[5] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 33};
`ifdef SIGN_MAG_OVF_EN
    vecs[6] = '{32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 33};
`else
    vecs[6] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 33};
`endif
    vecs[7] = '{32'hFFFF_FF00, 1'b1, 32'h0000_0100, 33};

    // Reset state.
    clr = 1'b1; bus.start = 1'b0; bus.A = 32'd0;
    tick(); tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sign", {31'd0, bus.sign}, 32'd0);
    chk("rst_mag",  bus.Mag, 32'd0);
    chk("rst_ovf",  {31'd0, get_ovf()}, 32'd0);

    // clr has priority over start.
    bus.start = 1'b1; bus.A = 32'hFFFF_FFFB;
    tick();
    chk("clr_prio_busy", {31'd0, bus.busy}, 32'd0);
    clr = 1'b0; bus.start = 1'b0;
    tick();

    // Directed table, run back-to-back (next start in the cycle after done).
    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].a, lat, busy_n);
      chk($sformatf("tbl%0d_lat", i),  lat, vecs[i].exp_lat);
      chk($sformatf("tbl%0d_busy", i), busy_n, vecs[i].exp_lat);
      chk($sformatf("tbl%0d_sign", i), {31'd0, bus.sign}, {31'd0, vecs[i].exp_sign});
      chk($sformatf("tbl%0d_mag", i),  bus.Mag, vecs[i].exp_mag);
      chk($sformatf("tbl%0d_ovf", i),  {31'd0, get_ovf()}, {31'd0, model_ovf(vecs[i].a)});
      tick();
      chk($sformatf("tbl%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
      chk($sformatf("tbl%0d_idle", i), {31'd0, bus.busy}, 32'd0);
    end

    // Results hold in IDLE (also ovf for the saturated case).
    run_conv(32'h8000_0000, lat, busy_n);
    repeat (5) tick();
    chk("hold_sign", {31'd0, bus.sign}, 32'd1);
    chk("hold_mag",  bus.Mag, model_mag(32'h8000_0000));
    chk("hold_ovf",  {31'd0, get_ovf()}, {31'd0, model_ovf(32'h8000_0000)});

    // Start during DONE is ignored.
    run_conv(32'hFFFF_FFFB, lat, busy_n);
    bus.start = 1'b1; bus.A = 32'h0000_0003;
    tick();
    bus.start = 1'b0;
    chk("done_start_ignored_busy", {31'd0, bus.busy}, 32'd0);
    chk("done_start_ignored_mag",  bus.Mag, 32'h0000_0005);
    tick();
    chk("done_start_ignored_done", {31'd0, bus.done}, 32'd0);

    // Re-start during SHIFT cycle 5 is ignored; exactly one done pulse.
    bus.start = 1'b1; bus.A = 32'hFFFF_FFFF;
    tick();
    bus.start = 1'b0;
    lat = 1; pulses = 0;
    repeat (4) begin bus.A = $urandom; tick(); lat++; end
    bus.start = 1'b1; bus.A = 32'h0000_0010;
    tick(); lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 100) begin bus.A = $urandom; tick(); lat++; end
    chk("restart_lat",  lat, 33);
    chk("restart_mag",  bus.Mag, 32'h0000_0001);
    chk("restart_sign", {31'd0, bus.sign}, 32'd1);
    repeat (40) begin tick(); if (bus.done) pulses++; end
    chk("restart_extra_done", pulses, 0);

    // clr at SHIFT cycle 10 abandons the conversion; immediate restart with A=0.
    bus.start = 1'b1; bus.A = 32'hFFFF_FF00;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy", {31'd0, bus.busy}, 32'd0);
    chk("clr_done", {31'd0, bus.done}, 32'd0);
    chk("clr_sign", {31'd0, bus.sign}, 32'd0);
    chk("clr_mag",  bus.Mag, 32'd0);
    chk("clr_ovf",  {31'd0, get_ovf()}, 32'd0);
    bus.start = 1'b1; bus.A = 32'd0;
    tick();
    bus.start = 1'b0;
    chk("post_clr_done", {31'd0, bus.done}, 32'd1);
    chk("post_clr_mag",  bus.Mag, 32'd0);
    pulses = 0;
    repeat (40) begin tick(); if (bus.done) pulses++; end
    chk("post_clr_no_stale_done", pulses, 0);

    // Random operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: ;
      endcase
      run_conv(a, lat, busy_n);
      chk("rnd_lat",  lat, a[31] ? 33 : 1);
      chk("rnd_sign", {31'd0, bus.sign}, {31'd0, a[31]});
      chk("rnd_mag",  bus.Mag, model_mag(a));
      chk("rnd_ovf",  {31'd0, get_ovf()}, {31'd0, model_ovf(a)});
      hold_mag  = model_mag(a);
      hold_sign = a[31];
      repeat ($urandom_range(1, 3)) begin bus.A = $urandom; tick(); end
      chk("rnd_hold_mag",  bus.Mag, hold_mag);
      chk("rnd_hold_sign", {31'd0, bus.sign}, {31'd0, hold_sign});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_mag_decode.md
SIGN_MAG_DECODE -- requirements
Module: sign_mag_decode

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to convert A; sampled at the rising edge of clk.
REQ-005 A  input  32  two's-complement operand; sampled only at an accepted start.
REQ-006 busy  output  1  high while state is SHIFT or DONE.
REQ-007 done  output  1  one-cycle pulse; result valid.
REQ-008 sign  output  1  sign of the last accepted operand (A[31]).
REQ-009 Mag  output  32  magnitude of the last accepted operand.
REQ-010 ovf  output  1  most-negative-input flag; present only with SIGN_MAG_OVF_EN.

Function
REQ-011 States SHALL be IDLE, SHIFT and DONE.
REQ-012 start SHALL be accepted only in IDLE; it SHALL be ignored in SHIFT and DONE, with no effect on operand, state or outputs.
REQ-013 On accept: operand register <= A, sign <= A[31], seen_one <= 0, bit counter <= 0.
REQ-014 Positive path: on accept with A[31]=0, the block SHALL load Mag <= A and move to DONE, so done is high in the cycle after the accept edge (latency 1).
REQ-015 Negative path: on accept with A[31]=1, the block SHALL move to SHIFT.
REQ-016 In SHIFT, one bit SHALL be processed per clk, LSB first: i = 0..31.
REQ-017 The bit rule SHALL be Mag[i] <= seen_one ? ~A[i] : A[i], then seen_one <= seen_one | A[i]. This is serial two's-complement negation.
REQ-018 SHIFT SHALL last exactly 32 cycles, leaving to DONE after i=31, so done is high 33 cycles after the accept edge.
REQ-019 DONE SHALL last exactly one cycle, with done=1, then the block SHALL return to IDLE.
REQ-020 During SHIFT, Mag SHALL hold partially written bits; it is valid only from done onward.
REQ-021 sign and Mag SHALL hold their values after DONE until the next accepted start.
REQ-022 A SHALL be don't-care outside the accept edge; changes to A during SHIFT SHALL NOT affect the result.
REQ-023 A=0 SHALL give sign=0 and Mag=0 via the positive path.
REQ-024 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.

Reset
REQ-025 clr at a rising edge SHALL force state to IDLE and busy, done, sign, Mag, ovf and the bit counter to 0.
REQ-026 clr SHALL take priority over start and over any in-progress SHIFT.
REQ-027 After clr, the abandoned conversion SHALL produce no done pulse.
REQ-028 A start in the first cycle after clr deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro SIGN_MAG_OVF_EN defined:
- the ovf port SHALL exist;
- for A=0x80000000, the result SHALL be Mag=0x7FFFFFFF, sign=1, with ovf=1 set together with done;
- ovf SHALL be held until the next accepted start or clr.
REQ-030 Macro SIGN_MAG_OVF_EN undefined:
- the ovf port SHALL be absent;
- A=0x80000000 SHALL give Mag=0x80000000, sign=1 (raw serial result).
- Latency SHALL be identical in both builds.

Verification
REQ-031 A=0x00000005, start pulse -> done 1 cycle later; sign=0, Mag=0x00000005; busy high for 1 cycle.
REQ-032 A=0xFFFFFFFB, start pulse -> done 33 cycles later; sign=1, Mag=0x00000005; busy high for 33 cycles.
REQ-033 A=0xFFFFFFFF, start re-pulsed with A=0x00000010 at SHIFT cycle 5 -> second start ignored; Mag=0x00000001, sign=1; exactly one done pulse.
REQ-034 A=0x80000000 -> with SIGN_MAG_OVF_EN: Mag=0x7FFFFFFF, ovf=1; without: Mag=0x80000000.
REQ-035 A=0xFFFFFF00, clr at SHIFT cycle 10 -> all outputs 0 next cycle, no done pulse; following start with A=0 -> done after 1 cycle, Mag=0.
REQ-036 Back-to-back: start again in the cycle after done, with A=0xFFFFFFFE -> accepted; Mag=0x00000002 after 33 cycles.
